// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - column-multiplexed 5x7 LED matrix scanner with blinking overlay
module varredura_matriz #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [34:0] saved,
    input  logic [34:0] overlay,
    output logic [4:0]  col_n,
    output logic [6:0]  row,
    output logic        frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FC_MAX = FW'(BLINK_FRAMES - 1);

    typedef enum logic {OFF, SCAN} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [2:0]    col_idx;
    logic [FW-1:0] frame_cnt;
    logic          blink;

    logic          step;
    logic          wrap;
    logic          frame_end;
    logic [2:0]    load_col;
    logic          load_blink;
    logic [6:0]    load_row;
    logic [4:0]    load_col_n;

    function automatic logic [6:0] pixel_row(input logic [2:0] c, input logic b,
                                             input logic [34:0] s, input logic [34:0] o);
        logic [6:0] r_bits;
        logic [5:0] k;
        r_bits = '0;
        for (int r = 0; r < 7; r++) begin
            k = 6'(r * 5) + 6'(c);
            r_bits[r] = s[k] ^ (o[k] & b);
        end
        return r_bits;
    endfunction

    // The wrap edge loads column 0 with the post-toggle blink so the new frame is consistent.
    always_comb begin
        step       = (prescaler == PS_MAX);
        wrap       = step && (col_idx == 3'd4);
        frame_end  = wrap && (frame_cnt == FC_MAX);
        load_col   = 3'd0;
        load_blink = 1'b0;
        if (state == SCAN) begin
            load_col   = (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
            load_blink = blink ^ frame_end;
        end
        load_row   = pixel_row(load_col, load_blink, saved, overlay);
        load_col_n = ~(5'b00001 << load_col);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OFF;
            prescaler  <= '0;
            col_idx    <= 3'd0;
            frame_cnt  <= '0;
            blink      <= 1'b0;
            col_n      <= 5'b11111;
            row        <= 7'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                OFF: begin
                    if (en) begin
                        state <= SCAN;
                        col_n <= load_col_n;
                        row   <= load_row;
                    end
                end
                SCAN: begin
                    if (!en) begin
                        state     <= OFF;
                        prescaler <= '0;
                        col_idx   <= 3'd0;
                        frame_cnt <= '0;
                        blink     <= 1'b0;
                        col_n     <= 5'b11111;
                        row       <= 7'd0;
                    end else if (step) begin
                        prescaler <= '0;
                        col_idx   <= load_col;
                        col_n     <= load_col_n;
                        row       <= load_row;
                        if (wrap) begin
                            frame_tick <= 1'b1;
                            frame_cnt  <= frame_end ? '0 : frame_cnt + FW'(1);
                            blink      <= load_blink;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// tb/tb_varredura_matriz.sv - scoreboard bench for varredura_matriz
module tb_varredura_matriz;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [34:0] saved;
    logic [34:0] overlay;
    logic [4:0]  col_n;
    logic [6:0]  row;
    logic        frame_tick;

    varredura_matriz #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .en(en), .saved(saved), .overlay(overlay),
        .col_n(col_n), .row(row), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] col_n;
        logic [6:0] row;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Time-based reference: m_t counts edges since the entry edge into SCAN.
    bit         m_on  = 0;
    int         m_t   = 0;
    logic [6:0] m_row = '0;

    function automatic logic [6:0] ref_row(int c, int b, logic [34:0] s, logic [34:0] o);
        logic [6:0] r_bits;
        logic [34:0] ob;
        ob = (b != 0) ? o : 35'd0;
        for (int r = 0; r < 7; r++) r_bits[r] = s[r*5 + c] ^ ob[r*5 + c];
        return r_bits;
    endfunction

    task automatic step(input string tag, input logic rst, input logic e,
                        input logic [34:0] s, input logic [34:0] o);
        exp_t x;
        exp_t got;
        int   c;
        reset = rst; en = e; saved = s; overlay = o;
        if (rst || !e) begin
            m_on = 0;
            m_t  = 0;
            x.col_n = 5'b11111; x.row = 7'd0; x.tick = 1'b0;
        end else begin
            if (!m_on) begin
                m_on = 1;
                m_t  = 0;
            end else begin
                m_t++;
            end
            c = (m_t / 4) % 5;
            if (m_t % 4 == 0) m_row = ref_row(c, (m_t / 40) % 2, s, o);
            x.col_n = ~(5'b00001 << c);
            x.row   = m_row;
            x.tick  = (m_t > 0) && (m_t % 20 == 0);
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        n_checks += 3;
        assert (col_n === got.col_n) else begin
            n_fail++;
            $error("FAIL %s col_n t=%0d observed=%b expected=%b", tag, m_t, col_n, got.col_n);
        end
        assert (row === got.row) else begin
            n_fail++;
            $error("FAIL %s row t=%0d observed=%b expected=%b", tag, m_t, row, got.row);
        end
        assert (frame_tick === got.tick) else begin
            n_fail++;
            $error("FAIL %s frame_tick t=%0d observed=%b expected=%b", tag, m_t, frame_tick, got.tick);
        end
    endtask

    localparam logic [34:0] CAD = (35'd1 << 34) | 35'd1;
    localparam logic [34:0] C3  = 35'd1 << 17;
    localparam logic [34:0] C0  = 35'd1 << 2;

    initial begin
        reset = 1'b1; en = 1'b1; saved = '0; overlay = '0;

        for (int i = 0; i < 3; i++) step("reset", 1, 1, '0, '0);
        for (int i = 0; i < 4; i++) step("release", 0, 1, '0, '0);

        step("cad_rst", 1, 1, CAD, '0);
        for (int i = 0; i < 45; i++) step("cadence", 0, 1, CAD, '0);

        step("blk_rst", 1, 1, '0, C3);
        for (int i = 0; i < 85; i++) step("blink", 0, 1, '0, C3);

        step("col_rst", 1, 1, C3, C3);
        for (int i = 0; i < 85; i++) step("collision", 0, 1, C3, C3);

        step("drop_rst", 1, 1, CAD, '0);
        for (int i = 0; i < 10; i++) step("pre_drop", 0, 1, CAD, '0);
        step("drop", 0, 0, CAD, '0);
        step("drop_hold", 0, 0, CAD, '0);
        for (int i = 0; i < 25; i++) step("reenter", 0, 1, CAD, '0);

        step("snap_rst", 1, 1, '0, '0);
        for (int i = 0; i < 10; i++) step("snap_pre", 0, 1, '0, '0);
        for (int i = 0; i < 22; i++) step("snapshot", 0, 1, C0, '0);
        n_checks++;
        assert (col_n === 5'b11011 && row === 7'b0000001) else begin
            n_fail++;
            $error("FAIL snap_reload observed=%b/%b expected=11011/0000001", col_n, row);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/varredura_matriz.md
# varredura_matriz

Column-multiplexed driver for the 5x7 LED matrix display. It consumes the 35-bit saved-map register and the 35-bit placement overlay register and scans one column at a time onto the physical matrix. Saved cells are shown steady; overlay cells blink, and cells present in both blink in antiphase to mark a collision.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles each column stays lit; legal range ≥ 2.
- BLINK_FRAMES, 25: full frames per blink half-period; legal range ≥ 1.

Ports:
- clk  input  1  system clock; everything is clocked on its rising edge.
- reset  input  1  synchronous, active-high; overrides all other inputs.
- en  input  1  display enable (machine-on switch); 0 blanks the display and holds the block idle.
- saved  input  35  saved-map cells. Cell index = row*5 + col, with col 0..4 = A..E and row 0..6.
- overlay  input  35  placement overlay cells, same indexing as saved.
- col_n  output  5  column select, active-low, one-hot; bit c drives column c.
- row  output  7  row data, active-high; bit r is the pixel at (current column, row r).
- frame_tick  output  1  one-cycle pulse each time the scan wraps from column 4 to column 0.

## Operation
- Two states: OFF and SCAN.
- Internal registers:
  - prescaler: 0..SCAN_DIV-1.
  - col_idx: 0..4.
  - frame_cnt: 0..BLINK_FRAMES-1.
  - blink: 1 bit.
- OFF state:
  - col_n = 11111, row = 0, frame_tick = 0.
  - prescaler, col_idx, frame_cnt and blink are all held at 0.
- OFF → SCAN: on an edge where en = 1. That edge loads column 0: col_n = 11110, row = pixel(0), prescaler = 0. frame_tick does not pulse on entry.
- Column step (in SCAN): an edge with prescaler = SCAN_DIV-1 steps the column.
  - prescaler → 0; col_idx → (col_idx+1) mod 5.
  - col_n and row are loaded for the new column.
  - Otherwise prescaler increments and the outputs hold.
- Frame wrap (the step from column 4 to column 0):
  - frame_tick = 1 for exactly that cycle.
  - frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and blink toggles on the same edge.
- SCAN → OFF: on any edge where en = 0. The block blanks on that edge and all counters and blink clear. Re-entry always restarts at column 0 with blink = 0 and frame_cnt = 0.
- Pixel rule, for row r of column c, with k = r*5 + c:
  - pixel bit r = saved[k] XOR (overlay[k] AND blink).
  - saved only: always lit.
  - overlay only: lit while blink = 1.
  - both: lit while blink = 0.
- Snapshot behaviour: row is computed only on the edge that loads a column. Changes to saved or overlay during a column do not appear until the next column load, so there is no tearing within a column.
- reset behaviour:
  - Forces the OFF state: col_n = 11111, row = 0, frame_tick = 0, all counters and blink = 0.
  - Asserting reset mid-scan blanks on the next edge.

## Timing
- Output latency: 1 cycle. The edge that loads column c uses the saved/overlay values present just before that edge.
- After reset is released with en = 1, column 0 is lit on the first edge.
- Each column is lit for exactly SCAN_DIV cycles. One frame is 5*SCAN_DIV cycles.
- frame_tick period is 5*SCAN_DIV cycles. The first pulse occurs 5*SCAN_DIV cycles after column 0 is first loaded.
- Blink half-period is BLINK_FRAMES frames. blink = 0 for the first BLINK_FRAMES frames after entering SCAN.
- col_n is never all-ones during SCAN and never has more than one 0 bit.
- Simultaneous events:
  - en falling on a column-step edge: blanking wins.
  - reset wins over everything.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_FRAMES = 2 unless noted.
- Reset: hold reset 3 cycles with en = 1 → col_n = 11111, row = 0, frame_tick = 0 throughout. First edge after release → col_n = 11110.
- Cadence: saved = bits 0 and 34 only, overlay = 0.
  - col_n sequence 11110, 11101, 11011, 10111, 01111, each held 4 cycles.
  - row = 0000001 in column 0, 1000000 in column 4, 0 in columns 1–3.
  - frame_tick pulses every 20 cycles, coinciding with the return to column 0.
- Blink: overlay = bit 17 (C3), saved = 0.
  - Column 2 row = 0000000 during frames 0–1 and 0001000 during frames 2–3.
  - blink toggles on every second frame_tick, giving an 80-cycle blink period.
- Collision: saved and overlay both bit 17 → column 2 row = 0001000 during frames 0–1 and 0000000 during frames 2–3.
- Enable drop: deassert en while column 2 is lit.
  - Next edge → col_n = 11111, row = 0.
  - Reassert en → column 0 on the next edge, blink = 0, and the first frame_tick 20 cycles later.
- Snapshot: change saved bit 2 (C0) while column 2 is lit.
  - row is unchanged until column 2 is next loaded.
  - On that load, row bit 0 reflects the new value.
